munoc_axi4l_master_arbiter: RTL and testbench

Round-robin arbiter that lets NUM_REQ AXI4-Lite requesters share one AXI4-Lite master network interface port. The read and write paths are arbitrated independently. Each path allows one outstanding transaction, so responses route back to the recorded grant owner without ID tags. It sits between local masters (debug, DMA control, CPU peripheral ports) and the AXI4-Lite master NI; its downstream port connects directly to the NI's rx4l* inputs.

---
 rtl/munoc_axi4l_master_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_munoc_axi4l_master_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/munoc_axi4l_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master NI port among NUM_REQ requesters.
// Read and write paths arbitrate independently, each with a single outstanding transaction.
module munoc_axi4l_master_arbiter #(
  parameter int unsigned NUM_REQ          = 2,
  parameter int unsigned BW_PLATFORM_ADDR = 32,
  parameter int unsigned BW_NODE_DATA     = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 comm_disable,
  // Requester side, slice i belongs to requester i
  input  logic [NUM_REQ*BW_PLATFORM_ADDR-1:0]  s_awaddr,
  input  logic [NUM_REQ-1:0]                   s_awvalid,
  output logic [NUM_REQ-1:0]                   s_awready,
  input  logic [NUM_REQ*BW_NODE_DATA-1:0]      s_wdata,
  input  logic [NUM_REQ*BW_NODE_DATA/8-1:0]    s_wstrb,
  input  logic [NUM_REQ-1:0]                   s_wvalid,
  output logic [NUM_REQ-1:0]                   s_wready,
  output logic [NUM_REQ*2-1:0]                 s_bresp,
  output logic [NUM_REQ-1:0]                   s_bvalid,
  input  logic [NUM_REQ-1:0]                   s_bready,
  input  logic [NUM_REQ*BW_PLATFORM_ADDR-1:0]  s_araddr,
  input  logic [NUM_REQ-1:0]                   s_arvalid,
  output logic [NUM_REQ-1:0]                   s_arready,
  output logic [NUM_REQ*BW_NODE_DATA-1:0]      s_rdata,
  output logic [NUM_REQ*2-1:0]                 s_rresp,
  output logic [NUM_REQ-1:0]                   s_rvalid,
  input  logic [NUM_REQ-1:0]                   s_rready,
  // NI side
  output logic [BW_PLATFORM_ADDR-1:0]          m_awaddr,
  output logic                                 m_awvalid,
  input  logic                                 m_awready,
  output logic [BW_NODE_DATA-1:0]              m_wdata,
  output logic [BW_NODE_DATA/8-1:0]            m_wstrb,
  output logic                                 m_wvalid,
  input  logic                                 m_wready,
  input  logic [1:0]                           m_bresp,
  input  logic                                 m_bvalid,
  output logic                                 m_bready,
  output logic [BW_PLATFORM_ADDR-1:0]          m_araddr,
  output logic                                 m_arvalid,
  input  logic                                 m_arready,
  input  logic [BW_NODE_DATA-1:0]              m_rdata,
  input  logic [1:0]                           m_rresp,
  input  logic                                 m_rvalid,
  output logic                                 m_rready,
  output logic                                 wr_busy,
  output logic                                 rd_busy
);

  localparam int unsigned BwStrb = BW_NODE_DATA / 8;
  localparam int unsigned IdxW   = $clog2(NUM_REQ);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic [1:0] {StWIdle, StWAddr, StWResp} w_state_e;
  typedef enum logic [1:0] {StRIdle, StRAddr, StRResp} r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;
  logic [IdxW-1:0] wg_q, wg_d, wptr_q, wptr_d;
  logic [IdxW-1:0] rg_q, rg_d, rptr_q, rptr_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;

  // First set request at or above ptr, wrapping past NUM_REQ-1.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [IdxW-1:0]    ptr);
    logic [IdxW-1:0] pick;
    logic [IdxW-1:0] idx;
    logic            found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IdxW'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    return (idx == LastIdx) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= StWIdle;
      r_state_q <= StRIdle;
      wg_q      <= '0;
      wptr_q    <= '0;
      rg_q      <= '0;
      rptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      wg_q      <= wg_d;
      wptr_q    <= wptr_d;
      rg_q      <= rg_d;
      rptr_q    <= rptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Write path
  always_comb begin
    w_state_d = w_state_q;
    wg_d      = wg_q;
    wptr_d    = wptr_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    m_awaddr  = '0;
    m_awvalid = 1'b0;
    m_wdata   = '0;
    m_wstrb   = '0;
    m_wvalid  = 1'b0;
    m_bready  = 1'b0;
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    wr_busy   = (w_state_q != StWIdle);

    if (w_state_q != StWIdle) begin
      m_awaddr = s_awaddr[wg_q*BW_PLATFORM_ADDR +: BW_PLATFORM_ADDR];
      m_wdata  = s_wdata[wg_q*BW_NODE_DATA +: BW_NODE_DATA];
      m_wstrb  = s_wstrb[wg_q*BwStrb +: BwStrb];
    end

    unique case (w_state_q)
      StWIdle: begin
        if (!comm_disable && |s_awvalid) begin
          wg_d      = rr_pick(s_awvalid, wptr_q);
          w_state_d = StWAddr;
        end
      end
      StWAddr: begin
        // Ready is masked once a channel is done so a queued next request is not consumed.
        m_awvalid       = s_awvalid[wg_q] & ~aw_done_q;
        m_wvalid        = s_wvalid[wg_q] & ~w_done_q;
        s_awready[wg_q] = m_awready & ~aw_done_q;
        s_wready[wg_q]  = m_wready & ~w_done_q;
        aw_done_d       = aw_done_q | (m_awvalid & m_awready);
        w_done_d        = w_done_q | (m_wvalid & m_wready);
        if (aw_done_d && w_done_d) begin
          w_state_d = StWResp;
        end
      end
      StWResp: begin
        s_bvalid[wg_q]          = m_bvalid;
        s_bresp[wg_q*2 +: 2]    = m_bresp;
        m_bready                = s_bready[wg_q];
        if (m_bvalid && s_bready[wg_q]) begin
          w_state_d = StWIdle;
          wptr_d    = next_idx(wg_q);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: w_state_d = StWIdle;
    endcase
  end

  // Read path
  always_comb begin
    r_state_d = r_state_q;
    rg_d      = rg_q;
    rptr_d    = rptr_q;
    m_araddr  = '0;
    m_arvalid = 1'b0;
    m_rready  = 1'b0;
    s_arready = '0;
    s_rvalid  = '0;
    s_rdata   = '0;
    s_rresp   = '0;
    rd_busy   = (r_state_q != StRIdle);

    if (r_state_q != StRIdle) begin
      m_araddr = s_araddr[rg_q*BW_PLATFORM_ADDR +: BW_PLATFORM_ADDR];
    end

    unique case (r_state_q)
      StRIdle: begin
        if (!comm_disable && |s_arvalid) begin
          rg_d      = rr_pick(s_arvalid, rptr_q);
          r_state_d = StRAddr;
        end
      end
      StRAddr: begin
        m_arvalid       = s_arvalid[rg_q];
        s_arready[rg_q] = m_arready;
        if (m_arvalid && m_arready) begin
          r_state_d = StRResp;
        end
      end
      StRResp: begin
        s_rvalid[rg_q]                               = m_rvalid;
        s_rdata[rg_q*BW_NODE_DATA +: BW_NODE_DATA]   = m_rdata;
        s_rresp[rg_q*2 +: 2]                         = m_rresp;
        m_rready                                     = s_rready[rg_q];
        if (m_rvalid && s_rready[rg_q]) begin
          r_state_d = StRIdle;
          rptr_d    = next_idx(rg_q);
        end
      end
      default: r_state_d = StRIdle;
    endcase
  end

endmodule

// File: tb/tb_munoc_axi4l_master_arbiter.sv
// Directed bench for munoc_axi4l_master_arbiter with two requesters; the read contention
// sequence is checked against a scoreboard of expected grant order and returned data.
module tb_munoc_axi4l_master_arbiter;

  localparam logic [31:0] Key = 32'h5EED_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        comm_disable;
  logic [63:0] s_awaddr;
  logic [1:0]  s_awvalid, s_awready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_wvalid, s_wready;
  logic [3:0]  s_bresp;
  logic [1:0]  s_bvalid, s_bready;
  logic [63:0] s_araddr;
  logic [1:0]  s_arvalid, s_arready;
  logic [63:0] s_rdata;
  logic [3:0]  s_rresp;
  logic [1:0]  s_rvalid, s_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [1:0]  m_bresp, m_rresp;
  logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;
  logic        wr_busy, rd_busy;

  int passed = 0;
  int total  = 0;

  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [31:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];
  int      got[2];

  munoc_axi4l_master_arbiter #(
    .NUM_REQ(2),
    .BW_PLATFORM_ADDR(32),
    .BW_NODE_DATA(32)
  ) dut (
    .clk(clk), .rst(rst), .comm_disable(comm_disable),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .wr_busy(wr_busy), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic ok);
    total++;
    if (ok === 1'b1) passed++;
    else $error("FAIL %s", tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; comm_disable = 1'b0;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    s_awvalid = 2'b11; s_wvalid = 2'b11; s_arvalid = 2'b11;
    s_bready = 2'b11; s_rready = 2'b11;
    m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
    m_bresp = 2'b00; m_bvalid = 1'b1; m_rdata = 32'hFFFF_FFFF; m_rresp = 2'b00; m_rvalid = 1'b1;
    #1;
    // Reset holds everything at zero even with all inputs active
    chk("rst_wr_busy", wr_busy === 1'b0);
    chk("rst_rd_busy", rd_busy === 1'b0);
    chk("rst_m_awvalid", m_awvalid === 1'b0);
    chk("rst_m_arvalid", m_arvalid === 1'b0);
    chk("rst_s_awready", s_awready === 2'b00);
    chk("rst_s_bvalid", s_bvalid === 2'b00);
    chk("rst_s_rdata", s_rdata === 64'h0);
    chk("rst_m_bready", m_bready === 1'b0);
    tick(); tick();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0; s_bready = '0; s_rready = '0;
    m_bvalid = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    rst = 1'b0;
    tick();

    // Single write from requester 1
    s_awaddr[63:32] = 32'h0000_1000; s_wdata[63:32] = 32'hDEAD_BEEF; s_wstrb[7:4] = 4'hF;
    s_awvalid = 2'b10; s_wvalid = 2'b10;
    #1;
    chk("sw_idle_awvalid", m_awvalid === 1'b0);
    chk("sw_idle_awaddr", m_awaddr === 32'h0);
    tick();
    chk("sw_awvalid", m_awvalid === 1'b1);
    chk("sw_awaddr", m_awaddr === 32'h0000_1000);
    chk("sw_wdata", m_wdata === 32'hDEAD_BEEF);
    chk("sw_wstrb", m_wstrb === 4'hF);
    chk("sw_awready", s_awready === 2'b10);
    chk("sw_wready", s_wready === 2'b10);
    tick();
    s_awvalid = '0; s_wvalid = '0; s_bready = 2'b10;
    #1;
    chk("sw_resp_busy", wr_busy === 1'b1);
    chk("sw_resp_nob", s_bvalid === 2'b00);
    tick(); tick();
    m_bvalid = 1'b1; m_bresp = 2'b00;
    #1;
    chk("sw_bvalid", s_bvalid === 2'b10);
    chk("sw_bresp", s_bresp === 4'b0000);
    chk("sw_bready", m_bready === 1'b1);
    tick();
    m_bvalid = 1'b0;
    #1;
    chk("sw_done_busy", wr_busy === 1'b0);

    // wptr now 0: both requesting, requester 0 wins
    s_awaddr = {32'h0000_2222, 32'h0000_1111}; s_awvalid = 2'b11; s_wvalid = 2'b11;
    tick();
    chk("wp_awready", s_awready === 2'b01);
    chk("wp_awaddr", m_awaddr === 32'h0000_1111);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; m_bresp = 2'b01; s_bready = 2'b11;
    #1;
    chk("wp_bvalid", s_bvalid === 2'b01);
    chk("wp_bresp", s_bresp === 4'b0001);
    tick();
    m_bvalid = 1'b0; m_bresp = 2'b00;

    // Read contention: both requesters hold AR for 4 reads each
    for (int t = 0; t < 8; t++) begin
      rd_exp_t e;
      e.req  = t % 2;
      e.addr = ((t % 2) == 1 ? 32'h0000_2000 : 32'h0000_1000) + 32'(4 * (t / 2));
      e.data = e.addr ^ Key;
      sb.push_back(e);
    end
    got[0] = 0; got[1] = 0;
    s_araddr = {32'h0000_2000, 32'h0000_1000}; s_arvalid = 2'b11; s_rready = 2'b11;
    for (int t = 0; t < 8; t++) begin
      rd_exp_t     e;
      logic [31:0] ni_addr;
      tick();
      e = sb.pop_front();
      chk("ct_arready", s_arready === 2'(1 << e.req));
      chk("ct_araddr", m_araddr === e.addr);
      ni_addr = m_araddr;
      tick();
      m_rvalid = 1'b1; m_rdata = ni_addr ^ Key;
      #1;
      chk("ct_rvalid", s_rvalid === 2'(1 << e.req));
      chk("ct_rdata", s_rdata[e.req*32 +: 32] === e.data);
      chk("ct_rdata_other", s_rdata[(1-e.req)*32 +: 32] === 32'h0);
      got[0] += int'(s_rvalid[0]);
      got[1] += int'(s_rvalid[1]);
      tick();
      m_rvalid = 1'b0; m_rdata = '0;
      s_araddr[e.req*32 +: 32] = s_araddr[e.req*32 +: 32] + 32'd4;
    end
    s_arvalid = '0; s_rready = '0;
    chk("ct_count0", got[0] === 4);
    chk("ct_count1", got[1] === 4);
    chk("ct_sb_empty", sb.size() === 0);

    // Split AW/W: AW at cycle 1, W only at cycle 4
    s_awaddr[31:0] = 32'h0000_3000; s_wdata[31:0] = 32'h1234_5678; s_wstrb[3:0] = 4'h3;
    s_awvalid = 2'b01; s_wvalid = 2'b00;
    tick();
    chk("sp_c1_awvalid", m_awvalid === 1'b1);
    chk("sp_c1_wvalid", m_wvalid === 1'b0);
    tick();
    chk("sp_c2_awvalid", m_awvalid === 1'b0);
    chk("sp_c2_awready", s_awready === 2'b00);
    tick();
    chk("sp_c3_awvalid", m_awvalid === 1'b0);
    chk("sp_c3_busy", wr_busy === 1'b1);
    tick();
    s_wvalid = 2'b01;
    #1;
    chk("sp_c4_wvalid", m_wvalid === 1'b1);
    chk("sp_c4_wdata", m_wdata === 32'h1234_5678);
    chk("sp_c4_wready", s_wready === 2'b01);
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1; s_bready = 2'b01;
    #1;
    chk("sp_c5_bvalid", s_bvalid === 2'b01);
    chk("sp_c5_wvalid", m_wvalid === 1'b0);
    tick();
    m_bvalid = 1'b0;

    // Concurrent: requester 0 writes, requester 1 reads, B delayed
    s_awvalid = 2'b01; s_wvalid = 2'b01;
    s_araddr[63:32] = 32'h0000_4000; s_arvalid = 2'b10;
    tick();
    chk("cc_arready", s_arready === 2'b10);
    chk("cc_araddr", m_araddr === 32'h0000_4000);
    chk("cc_awvalid", m_awvalid === 1'b1);
    tick();
    s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
    m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b10; s_rready = 2'b10; s_bready = 2'b01;
    #1;
    chk("cc_rvalid", s_rvalid === 2'b10);
    chk("cc_rdata", s_rdata === {32'hCAFE_F00D, 32'h0});
    chk("cc_rresp", s_rresp === 4'b1000);
    tick();
    m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    #1;
    chk("cc_rd_idle", rd_busy === 1'b0);
    for (int c = 0; c < 9; c++) begin
      chk("cc_wr_busy", wr_busy === 1'b1);
      tick();
    end
    m_bvalid = 1'b1;
    #1;
    chk("cc_bvalid", s_bvalid === 2'b01);
    tick();
    m_bvalid = 1'b0; s_rready = '0;
    #1;
    chk("cc_wr_idle", wr_busy === 1'b0);

    // comm_disable blocks grants; raised during R_RESP the beat still completes
    comm_disable = 1'b1; s_araddr[31:0] = 32'h0000_5000; s_arvalid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("cd_arvalid", m_arvalid === 1'b0);
      chk("cd_rd_busy", rd_busy === 1'b0);
    end
    comm_disable = 1'b0;
    tick();
    chk("cd_grant", m_arvalid === 1'b1);
    chk("cd_arready", s_arready === 2'b01);
    tick();
    comm_disable = 1'b1; s_arvalid = '0; m_rvalid = 1'b1; m_rdata = 32'h0BAD_F00D; s_rready = 2'b01;
    #1;
    chk("cd_rvalid", s_rvalid === 2'b01);
    chk("cd_rready", m_rready === 1'b1);
    tick();
    m_rvalid = 1'b0; m_rdata = '0; s_rready = '0;
    #1;
    chk("cd_rd_done", rd_busy === 1'b0);
    comm_disable = 1'b0;

    // Reset during W_RESP of requester 1 (wptr was 1)
    s_awaddr[63:32] = 32'h0000_6000; s_awvalid = 2'b10; s_wvalid = 2'b10; s_bready = 2'b00;
    tick();
    tick();
    s_awvalid = '0; s_wvalid = '0; m_bvalid = 1'b1;
    #1;
    chk("rr_in_resp", s_bvalid === 2'b10);
    rst = 1'b1;
    #1;
    chk("rr_wr_busy", wr_busy === 1'b0);
    chk("rr_bvalid", s_bvalid === 2'b00);
    chk("rr_awaddr", m_awaddr === 32'h0);
    tick();
    rst = 1'b0; m_bvalid = 1'b0;
    s_awaddr = {32'h0000_7001, 32'h0000_7000}; s_awvalid = 2'b11; s_wvalid = 2'b11;
    tick();
    chk("rr_grant0", s_awready === 2'b01);
    chk("rr_awaddr0", m_awaddr === 32'h0000_7000);
    tick();
    s_awvalid = 2'b10; s_wvalid = 2'b10; m_bvalid = 1'b1; s_bready = 2'b11;
    tick();
    m_bvalid = 1'b0;
    tick();
    chk("rr_grant1", s_awready === 2'b10);
    chk("rr_awaddr1", m_awaddr === 32'h0000_7001);
    s_awvalid = '0; s_wvalid = '0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
